// File: rtl/byte_cmd_serializer.sv
// Buffers (address, data) write commands in a small FIFO and serializes each one into a
// 7-byte MSB-first packet on an 8-bit valid bus, stalling on the receiver's Rdyn.
module byte_cmd_serializer #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned GAP_CYCLES      = 0
) (
    input  logic                       Clk,
    input  logic                       ARstn,
    input  logic [23:0]                WriteAddr,
    input  logic [31:0]                WriteData,
    input  logic                       WriteValid,
    output logic                       WriteReady,
    output logic [7:0]                 Data,
    output logic                       DataValid,
    input  logic                       Rdyn,
    output logic                       Busy,
    output logic [FIFO_DEPTH_LOG2:0]   FifoCount
);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    localparam logic [FIFO_DEPTH_LOG2:0] FullCount = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);
    localparam logic [7:0]               GapLoad   = 8'(GAP_CYCLES);
    localparam bit                       HasGap    = (GAP_CYCLES != 0);

    logic [23:0]                addr_mem [FIFO_DEPTH];
    logic [31:0]                data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;

    state_e      state_q, gap_next_q;
    logic [55:0] shift_q;
    logic [2:0]  idx_q;
    logic [7:0]  gap_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;

    logic   push, pop, last_byte;
    state_e send_next;

    assign WriteReady = (count_q != FullCount);
    assign push       = WriteValid && WriteReady;
    assign pop        = (state_q == StIdle) && (count_q != '0) && !Rdyn;
    assign last_byte  = (idx_q == 3'd6);
    assign send_next  = last_byte ? StIdle : StSend;

    assign Data      = data_q;
    assign DataValid = valid_q;
    assign Busy      = busy_q;
    assign FifoCount = count_q;

    // Storage needs no reset; only pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= WriteAddr;
            data_mem[wr_ptr_q] <= WriteData;
        end
    end

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            state_q    <= StIdle;
            gap_next_q <= StIdle;
            shift_q    <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= (state_q != StIdle) || (count_q != '0);
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        data_q  <= addr_mem[rd_ptr_q][23:16];
                        shift_q <= {addr_mem[rd_ptr_q][15:0], data_mem[rd_ptr_q], 8'h00};
                        valid_q <= 1'b1;
                        idx_q   <= 3'd1;
                        if (HasGap) begin
                            state_q    <= StGap;
                            gap_q      <= GapLoad;
                            gap_next_q <= StSend;
                        end else begin
                            state_q <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (!Rdyn) begin
                        data_q  <= shift_q[55:48];
                        shift_q <= {shift_q[47:0], 8'h00};
                        valid_q <= 1'b1;
                        idx_q   <= last_byte ? 3'd0 : idx_q + 3'd1;
                        if (HasGap) begin
                            state_q    <= StGap;
                            gap_q      <= GapLoad;
                            gap_next_q <= send_next;
                        end else begin
                            state_q <= send_next;
                        end
                    end
                end
                StGap: begin
                    // Leaving on the cycle the counter reaches zero gives exactly GAP_CYCLES idle cycles.
                    if (gap_q <= 8'd1) begin
                        gap_q   <= '0;
                        state_q <= gap_next_q;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
